// File: rtl/pixel_addr_gen_pipe_pkg.sv
// Shared types and helpers for the pixel address generator pipeline.
// AUX command codes, the pixel_cmd header layout and the bpp-code to shift mapping.
package pixel_addr_pkg;

  typedef enum logic [3:0] {
    AUX_NOP           = 4'd0,
    AUX_PXWRI         = 4'd1,
    AUX_PXWRI2        = 4'd2,
    AUX_PXWRI3        = 4'd3,
    AUX_PXWRI4        = 4'd4,
    AUX_UNUSED5       = 4'd5,
    AUX_PXCOPY        = 4'd6,
    AUX_SETARGB       = 4'd7,
    AUX_CLIPMIN       = 4'd8,
    AUX_CLIPMAX       = 4'd9,
    AUX_RST_PXWRI_M   = 4'd10,
    AUX_RST_PXPASTE_M = 4'd11,
    AUX_DSTRWDTH      = 4'd12,
    AUX_SRCRWDTH      = 4'd13,
    AUX_DSTMADDR      = 4'd14,
    AUX_SRCMADDR      = 4'd15
  } aux_cmd_t;

  // Upper 20 bits of pixel_cmd; the address field below it is sized by the top module.
  typedef struct packed {
    aux_cmd_t    aux;
    logic [7:0]  colour;
    logic [3:0]  bpp;
    logic [3:0]  bit_off;
  } pixel_hdr_t;

  localparam int HDR_W = 20;

  // floor(log2(code+1)): codes 0/1/3/7/15 select 1/2/4/8/16 bits per pixel.
  function automatic logic [2:0] bpp_shift(input logic [3:0] code);
    logic [4:0] n;
    n = {1'b0, code} + 5'd1;
    if (n[4])      return 3'd4;
    else if (n[3]) return 3'd3;
    else if (n[2]) return 3'd2;
    else if (n[1]) return 3'd1;
    else           return 3'd0;
  endfunction

  function automatic logic is_draw_cmd(input aux_cmd_t a);
    return (a == AUX_PXWRI) || (a == AUX_PXWRI2) || (a == AUX_PXWRI3) || (a == AUX_PXWRI4);
  endfunction

  function automatic logic is_pixel_cmd(input aux_cmd_t a);
    return is_draw_cmd(a) || (a == AUX_PXCOPY);
  endfunction

  function automatic logic is_pass_cmd(input aux_cmd_t a);
    return (a == AUX_SETARGB) || (a == AUX_RST_PXWRI_M) || (a == AUX_RST_PXPASTE_M);
  endfunction

endpackage

// File: rtl/pag_mul_pipe.sv
// Unsigned a*b multiplier with STAGES register stages, all advancing on en.
module pag_mul_pipe #(
  parameter int A_W    = 12,
  parameter int B_W    = 16,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic [A_W+B_W-1:0] p
);

  localparam int P_W = A_W + B_W;

  logic [P_W-1:0] prod_q [STAGES];
  logic [P_W-1:0] prod_d [STAGES];

  always_comb begin
    for (int i = 0; i < STAGES; i++) prod_d[i] = prod_q[i];
    if (en) begin
      prod_d[0] = P_W'(a) * P_W'(b);
      for (int i = 1; i < STAGES; i++) prod_d[i] = prod_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) prod_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) prod_q[i] <= prod_d[i];
    end
  end

  assign p = prod_q[STAGES-1];

endmodule

// File: rtl/pixel_addr_gen_pipe.sv
// Pixel address generator: AUX draw commands -> word address, bit offset and bpp.
// Optional clip window enabled by defining PIXEL_ADDR_GEN_CLIP_EN.
module pixel_addr_gen_pipe
  import pixel_addr_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int COORD_W    = 12,
  parameter int MUL_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              draw_cmd_rdy,
  input  logic [35:0]       draw_cmd,
  input  logic              draw_busy,
  output logic              pixel_cmd_rdy,
  output logic [ADDR_W+19:0] pixel_cmd,
  output logic              pix_adr_busy
);

  localparam int WIDTH_W = 16;
  localparam int PROD_W  = COORD_W + WIDTH_W;
  localparam int PIX_W   = COORD_W + 17;
  localparam int BOFF_W  = PIX_W + 4;
  localparam int CMD_W   = ADDR_W + HDR_W;

  typedef struct packed {
    logic [WIDTH_W-1:0] width;
    logic [3:0]         code;
    logic [ADDR_W-1:0]  base;
  } desc_t;

  typedef struct packed {
    logic              valid;
    aux_cmd_t          aux;
    logic [31:0]       raw;
    logic [3:0]        code;
    logic [ADDR_W-1:0] base;
  } side_t;

  typedef struct packed {
    side_t              side;
    logic [WIDTH_W-1:0] width;
  } s1_t;

  typedef struct packed {
    pixel_hdr_t        hdr;
    logic [ADDR_W-1:0] addr;
  } pixel_cmd_t;

  aux_cmd_t in_aux;
  logic     stage_en;
  logic     accept;
  logic     clip_drop;

  desc_t dst_desc_q, dst_desc_d, src_desc_q, src_desc_d, sel_desc;
  s1_t   s1_q, s1_d;
  side_t side_q [MUL_STAGES];
  side_t side_d [MUL_STAGES];
  side_t last;

  logic [PROD_W-1:0] mul_p;
  logic [PIX_W-1:0]  pix;
  logic [BOFF_W-1:0] bit_off;
  logic [ADDR_W-1:0] byte_addr;
  pixel_cmd_t        pix_word;
  logic [CMD_W-1:0]  pass_word;

  logic             pixel_cmd_rdy_q, pixel_cmd_rdy_d;
  logic [CMD_W-1:0] pixel_cmd_q, pixel_cmd_d;

  // The whole pipe freezes while the writer refuses a presented command.
  assign in_aux       = aux_cmd_t'(draw_cmd[35:32]);
  assign pix_adr_busy = pixel_cmd_rdy_q && draw_busy && !reset;
  assign stage_en     = !pix_adr_busy;
  assign accept       = draw_cmd_rdy && stage_en;

  always_comb begin
    dst_desc_d = dst_desc_q;
    src_desc_d = src_desc_q;
    if (accept) begin
      case (in_aux)
        AUX_DSTRWDTH: begin
          dst_desc_d.width = draw_cmd[15:0];
          dst_desc_d.code  = draw_cmd[27:24];
        end
        AUX_SRCRWDTH: begin
          src_desc_d.width = draw_cmd[15:0];
          src_desc_d.code  = draw_cmd[27:24];
        end
        AUX_DSTMADDR: dst_desc_d.base = draw_cmd[ADDR_W-1:0];
        AUX_SRCMADDR: src_desc_d.base = draw_cmd[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dst_desc_q <= '0;
      src_desc_q <= '0;
    end else begin
      dst_desc_q <= dst_desc_d;
      src_desc_q <= src_desc_d;
    end
  end

`ifdef PIXEL_ADDR_GEN_CLIP_EN
  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } point_t;

  point_t clip_min_q, clip_min_d, clip_max_q, clip_max_d, in_pt;

  always_comb begin
    in_pt.x    = draw_cmd[COORD_W-1:0];
    in_pt.y    = draw_cmd[12 +: COORD_W];
    clip_min_d = clip_min_q;
    clip_max_d = clip_max_q;
    if (accept && (in_aux == AUX_CLIPMIN)) clip_min_d = in_pt;
    if (accept && (in_aux == AUX_CLIPMAX)) clip_max_d = in_pt;
    clip_drop = is_draw_cmd(in_aux) &&
                ((in_pt.x < clip_min_q.x) || (in_pt.x > clip_max_q.x) ||
                 (in_pt.y < clip_min_q.y) || (in_pt.y > clip_max_q.y));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clip_min_q <= '0;
      clip_max_q <= '1;
    end else begin
      clip_min_q <= clip_min_d;
      clip_max_q <= clip_max_d;
    end
  end
`else
  assign clip_drop = 1'b0;
`endif

  // S1 samples the descriptor registers, so a config from the previous cycle is already visible.
  always_comb begin
    sel_desc = (in_aux == AUX_PXCOPY) ? src_desc_q : dst_desc_q;
    s1_d     = s1_q;
    if (stage_en) begin
      s1_d.side.valid = accept && (is_pixel_cmd(in_aux) || is_pass_cmd(in_aux)) && !clip_drop;
      s1_d.side.aux   = in_aux;
      s1_d.side.raw   = draw_cmd[31:0];
      s1_d.side.code  = sel_desc.code;
      s1_d.side.base  = sel_desc.base;
      s1_d.width      = sel_desc.width;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) s1_q <= '0;
    else       s1_q <= s1_d;
  end

  pag_mul_pipe #(
    .A_W    (COORD_W),
    .B_W    (WIDTH_W),
    .STAGES (MUL_STAGES)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .en    (stage_en),
    .a     (s1_q.side.raw[12 +: COORD_W]),
    .b     (s1_q.width),
    .p     (mul_p)
  );

  always_comb begin
    for (int i = 0; i < MUL_STAGES; i++) side_d[i] = side_q[i];
    if (stage_en) begin
      side_d[0] = s1_q.side;
      for (int i = 1; i < MUL_STAGES; i++) side_d[i] = side_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_STAGES; i++) side_q[i] <= '0;
    end else begin
      for (int i = 0; i < MUL_STAGES; i++) side_q[i] <= side_d[i];
    end
  end

  // Shift/add stage feeds the output register directly.
  always_comb begin
    last      = side_q[MUL_STAGES-1];
    pix       = PIX_W'(mul_p) + PIX_W'(last.raw[COORD_W-1:0]);
    bit_off   = BOFF_W'(pix) << bpp_shift(last.code);
    byte_addr = last.base + ADDR_W'(bit_off >> 3);

    pix_word.hdr.aux     = last.aux;
    pix_word.hdr.colour  = last.raw[31:24];
    pix_word.hdr.bpp     = last.code;
    pix_word.hdr.bit_off = bit_off[3:0];
    pix_word.addr        = {byte_addr[ADDR_W-1:1], 1'b0};

    pass_word              = '0;
    pass_word[31:0]        = last.raw;
    pass_word[CMD_W-1 -: 4] = last.aux;
  end

  always_comb begin
    pixel_cmd_rdy_d = pixel_cmd_rdy_q;
    pixel_cmd_d     = pixel_cmd_q;
    if (stage_en) begin
      pixel_cmd_rdy_d = last.valid;
      pixel_cmd_d     = '0;
      if (last.valid) pixel_cmd_d = is_pass_cmd(last.aux) ? pass_word : CMD_W'(pix_word);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_cmd_rdy_q <= 1'b0;
      pixel_cmd_q     <= '0;
    end else begin
      pixel_cmd_rdy_q <= pixel_cmd_rdy_d;
      pixel_cmd_q     <= pixel_cmd_d;
    end
  end

  assign pixel_cmd_rdy = pixel_cmd_rdy_q;
  assign pixel_cmd     = pixel_cmd_q;

endmodule

// File: tb/tb_pixel_addr_gen_pipe.sv
// Self-checking bench for pixel_addr_gen_pipe: directed cases plus randomized traffic
// checked against an arithmetic reference model and an expected-output queue.
module tb_pixel_addr_gen_pipe;

  localparam int ADDR_W     = 24;
  localparam int COORD_W    = 12;
  localparam int MUL_STAGES = 2;
  localparam int CMD_W      = ADDR_W + 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              draw_cmd_rdy;
  logic [35:0]       draw_cmd;
  logic              draw_busy;
  logic              pixel_cmd_rdy;
  logic [CMD_W-1:0]  pixel_cmd;
  logic              pix_adr_busy;

  pixel_addr_gen_pipe #(
    .ADDR_W     (ADDR_W),
    .COORD_W    (COORD_W),
    .MUL_STAGES (MUL_STAGES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .draw_cmd_rdy  (draw_cmd_rdy),
    .draw_cmd      (draw_cmd),
    .draw_busy     (draw_busy),
    .pixel_cmd_rdy (pixel_cmd_rdy),
    .pixel_cmd     (pixel_cmd),
    .pix_adr_busy  (pix_adr_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CMD_W-1:0] exp_q[$];

  longint dst_w, dst_code, dst_base, src_w, src_code, src_base;
  longint clip_min_x, clip_min_y, clip_max_x, clip_max_y;

  int busy_cnt  = 0;
  bit rand_busy = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    dst_w = 0; dst_code = 0; dst_base = 0;
    src_w = 0; src_code = 0; src_base = 0;
    clip_min_x = 0; clip_min_y = 0;
    clip_max_x = 4095; clip_max_y = 4095;
  endtask

  // Reference address arithmetic straight from the command semantics.
  function automatic logic [CMD_W-1:0] pixelWord(input logic [3:0] aux, input logic [31:0] p,
                                                 input longint w, input longint code,
                                                 input longint base);
    longint x, y, pix, bpp, shift, bitoff, addr;
    logic [3:0] code4, bit4;
    logic [ADDR_W-1:0] a;
    x = longint'(p[11:0]);
    y = longint'(p[23:12]);
    pix = y * w + x;
    bpp = code + 1;
    shift = 0;
    while ((longint'(1) << (shift + 1)) <= bpp) shift++;
    bitoff = pix * (longint'(1) << shift);
    addr = (base + bitoff / 8) % (longint'(1) << ADDR_W);
    addr = addr - (addr % 2);
    code4 = 4'(code);
    bit4 = 4'(bitoff % 16);
    a = ADDR_W'(addr);
    return {aux, p[31:24], code4, bit4, a};
  endfunction

  task automatic modelAccept(input logic [3:0] aux, input logic [31:0] p);
    longint x, y;
    x = longint'(p[11:0]);
    y = longint'(p[23:12]);
    case (aux)
      4'd1, 4'd2, 4'd3, 4'd4: begin
`ifdef PIXEL_ADDR_GEN_CLIP_EN
        if (x >= clip_min_x && x <= clip_max_x && y >= clip_min_y && y <= clip_max_y)
          exp_q.push_back(pixelWord(aux, p, dst_w, dst_code, dst_base));
`else
        exp_q.push_back(pixelWord(aux, p, dst_w, dst_code, dst_base));
`endif
      end
      4'd6: exp_q.push_back(pixelWord(aux, p, src_w, src_code, src_base));
      4'd7, 4'd10, 4'd11: exp_q.push_back({aux, 8'h00, p});
`ifdef PIXEL_ADDR_GEN_CLIP_EN
      4'd8: begin clip_min_x = x; clip_min_y = y; end
      4'd9: begin clip_max_x = x; clip_max_y = y; end
`endif
      4'd12: begin dst_w = longint'(p[15:0]); dst_code = longint'(p[27:24]); end
      4'd13: begin src_w = longint'(p[15:0]); src_code = longint'(p[27:24]); end
      4'd14: dst_base = longint'(p[23:0]);
      4'd15: src_base = longint'(p[23:0]);
      default: ;
    endcase
  endtask

  // One clock: update draw_busy, sample the handshake at negedge, return at posedge+1.
  task automatic step(output logic busy_seen);
    if (busy_cnt > 0) begin
      draw_busy = 1'b1;
      busy_cnt--;
    end else if (rand_busy) begin
      draw_busy = ($urandom_range(0, 3) == 0);
    end else begin
      draw_busy = 1'b0;
    end
    @(negedge clk);
    busy_seen = pix_adr_busy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic b;
    repeat (n) step(b);
  endtask

  task automatic applyStimulus(input logic [3:0] aux, input logic [31:0] p);
    logic busy_seen;
    bit done;
    done = 1'b0;
    draw_cmd = {aux, p};
    draw_cmd_rdy = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      step(busy_seen);
      if (!busy_seen) begin
        modelAccept(aux, p);
        done = 1'b1;
      end
    end
    draw_cmd_rdy = 1'b0;
    checkOutput("accepted", 64'(done), 64'd1);
  endtask

  task automatic expectNext(input string tag, input logic [CMD_W-1:0] exp);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (pixel_cmd_rdy && !draw_busy) begin
        checkOutput(tag, pixel_cmd, exp);
        found = 1'b1;
      end
    end
    checkOutput({tag, "_seen"}, 64'(found), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (exp_q.size() != 0 || pixel_cmd_rdy); k++) idle(1);
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: every consumed command must match the queue head; stalled output must hold.
  logic [CMD_W-1:0] held;
  bit               have_held = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("busy_in_reset", 64'(pix_adr_busy), 64'd0);
      have_held = 1'b0;
    end else begin
      checkOutput("busy_flag", 64'(pix_adr_busy), 64'(pixel_cmd_rdy && draw_busy));
      if (have_held) checkOutput("rdy_held", 64'(pixel_cmd_rdy), 64'd1);
      if (pixel_cmd_rdy) begin
        if (have_held) checkOutput("stall_stable", pixel_cmd, held);
        if (draw_busy) begin
          held = pixel_cmd;
          have_held = 1'b1;
        end else begin
          have_held = 1'b0;
          if (exp_q.size() == 0) checkOutput("unexpected_output", 64'(pixel_cmd_rdy), 64'd0);
          else checkOutput("pixel_cmd", pixel_cmd, exp_q.pop_front());
        end
      end else begin
        have_held = 1'b0;
      end
    end
  end

  initial begin
    int lat;
    bit seen;
    logic [3:0] r_aux;
    logic [31:0] r_p;

    modelReset();
    reset = 1'b1;
    draw_cmd_rdy = 1'b0;
    draw_cmd = '0;
    draw_busy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_rdy", 64'(pixel_cmd_rdy), 64'd0);
    checkOutput("reset_cmd", pixel_cmd, 64'd0);
    reset = 1'b0;
    draw_busy = 1'b0;

    $display("[TB] basic 8bpp write with latency");
    applyStimulus(4'd14, 32'h0000_1000);
    applyStimulus(4'd12, {4'h0, 4'h7, 8'h00, 16'd320});
    applyStimulus(4'd1, {8'h3C, 12'd2, 12'd5});
    lat = 0;
    seen = 1'b0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (pixel_cmd_rdy) begin
        lat = k;
        seen = 1'b1;
      end
    end
    checkOutput("latency", 64'(lat), 64'(MUL_STAGES + 2));
    checkOutput("t1_cmd", pixel_cmd, {4'd1, 8'h3C, 4'd7, 4'd8, 24'h001284});
    @(posedge clk); #1;

    $display("[TB] 1bpp write");
    applyStimulus(4'd14, 32'h0000_0000);
    applyStimulus(4'd12, {4'h0, 4'h0, 8'h00, 16'd640});
    applyStimulus(4'd1, {8'hA5, 12'd0, 12'd13});
    expectNext("t2_cmd", {4'd1, 8'hA5, 4'd0, 4'd13, 24'h000000});

    $display("[TB] back-to-back with stall");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'd1, {8'(k + 8'h40), 12'(k), 12'(k * 3)});
      if (k == 3) busy_cnt = 5;
    end
    drain();

    $display("[TB] config takes effect on the next command");
    applyStimulus(4'd14, 32'h0000_2000);
    applyStimulus(4'd12, {4'h0, 4'h7, 8'h00, 16'd100});
    applyStimulus(4'd2, {8'h5A, 12'd1, 12'd0});
    expectNext("t4_cmd", {4'd2, 8'h5A, 4'd7, 4'd0, 24'h002064});

    $display("[TB] address wrap and pass-through");
    applyStimulus(4'd14, 32'h00FF_FFF0);
    applyStimulus(4'd12, {4'h0, 4'hF, 8'h00, 16'd16});
    applyStimulus(4'd1, {8'h11, 12'd1, 12'd0});
    expectNext("t5_wrap", {4'd1, 8'h11, 4'hF, 4'd0, 24'h000010});
    applyStimulus(4'd7, 32'h80FF_00FF);
    expectNext("t5_argb", {4'd7, 8'h00, 32'h80FF_00FF});
    applyStimulus(4'd5, 32'h1234_5678);
    applyStimulus(4'd0, 32'h0);
    applyStimulus(4'd6, {8'h22, 12'd1, 12'd2});
    drain();

`ifdef PIXEL_ADDR_GEN_CLIP_EN
    $display("[TB] clip window");
    applyStimulus(4'd9, {8'h00, 12'hFFF, 12'd319});
    applyStimulus(4'd13, {4'h0, 4'h7, 8'h00, 16'd320});
    applyStimulus(4'd15, 32'h0000_4000);
    applyStimulus(4'd1, {8'h33, 12'd0, 12'd400});
    applyStimulus(4'd6, {8'h44, 12'd0, 12'd400});
    expectNext("t6_copy", {4'd6, 8'h44, 4'd7, 4'd0, 24'h004190});
    drain();
`endif

    $display("[TB] reset mid-stream");
    applyStimulus(4'd1, {8'h77, 12'd3, 12'd4});
    applyStimulus(4'd1, {8'h78, 12'd3, 12'd5});
    applyStimulus(4'd1, {8'h79, 12'd3, 12'd6});
    reset = 1'b1;
    draw_busy = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    modelReset();
    @(negedge clk);
    checkOutput("midrst_rdy", 64'(pixel_cmd_rdy), 64'd0);
    checkOutput("midrst_cmd", pixel_cmd, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    applyStimulus(4'd1, {8'h99, 12'd3, 12'd7});
    expectNext("postrst_cmd", {4'd1, 8'h99, 4'd0, 4'd7, 24'h000000});

    $display("[TB] randomized traffic");
    rand_busy = 1'b1;
    for (int k = 0; k < 400; k++) begin
      r_aux = 4'($urandom_range(0, 15));
      r_p = $urandom;
      applyStimulus(r_aux, r_p);
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    rand_busy = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
